// File: rtl/board_renderer.sv
// Board renderer: a two-stage VGA pixel pipeline over a double-buffered board row.
// It also holds the row-fetch FSM and a fading popup cell to the right of the board.
module board_renderer #(
  parameter int          COLS       = 10,
  parameter int          ROWS       = 20,
  parameter int          CELL_PX    = 21,
  parameter int          LEFT_X     = 213,
  parameter logic [23:0] BG         = 24'h00FC39,
  parameter int          POP_FRAMES = 60
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 hs,
  input  logic                 frame_tick,
  output logic                 row_req,
  output logic [7:0]           row_num,
  input  logic                 row_ack,
  input  logic [COLS*12-1:0]   row_data,
  input  logic                 pop_trigger,
  input  logic [6:0]           pop_row,
  output logic [7:0]           Red,
  output logic [7:0]           Green,
  output logic [7:0]           Blue,
  output logic                 fetch_err
);

  localparam int          RIGHT_X    = LEFT_X + COLS * CELL_PX;
  localparam int          CW         = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [10:0] L_LEFT     = 11'(LEFT_X);
  localparam logic [10:0] L_RIGHT    = 11'(RIGHT_X);
  localparam logic [10:0] L_POP_END  = 11'(RIGHT_X + CELL_PX);
  localparam logic [10:0] L_CELL     = 11'(CELL_PX);
  localparam logic [10:0] L_CELL_M1  = 11'(CELL_PX - 1);
  localparam logic [10:0] L_ROWS     = 11'(ROWS);
  localparam logic [10:0] L_BOARD_H  = 11'(ROWS * CELL_PX);
  localparam logic [10:0] L_LAST_Y   = 11'd479;
  localparam logic [12:0] P_CELL     = 13'(CELL_PX);
  localparam logic [6:0]  L_ROWS7    = 7'(ROWS);
  localparam logic [5:0]  L_POP_LAST = 6'(POP_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_READY} fetch_state_t;
  typedef enum logic [1:0] {RG_BG, RG_BOARD, RG_POP} region_t;

  fetch_state_t r_state;
  logic         r_hs_d;
  logic         r_row_req;
  logic [7:0]   r_row_num;
  logic         r_fetch_err;
  logic         r_disp_sel;            // 0: buf0 is displayed, buf1 is filled
  logic [11:0]  r_buf0 [COLS];
  logic [11:0]  r_buf1 [COLS];

  logic         r_pop_active;
  logic [5:0]   r_pop_cnt;
  logic [6:0]   r_pop_row;

  region_t      r_s1_region;
  logic [CW-1:0] r_s1_col;
  logic         r_s1_border;
  logic [7:0]   r_red, r_green, r_blue;

  // Coordinate arithmetic, all 11 bits or wider so nothing wraps.
  logic [10:0]  w_x, w_y, w_y1, w_y1_row, w_y1_off, w_y_off;
  logic [11:0]  w_x_diff;
  logic [10:0]  w_x_rel, w_x_off;
  logic [CW-1:0] w_col;
  logic         w_hs_rise, w_trig_row, w_trig_wrap, w_trigger, w_swap;
  logic         w_on_board, w_border, w_on_pop;
  logic [12:0]  w_y13, w_pop_top, w_pop_bot;

  assign w_x         = {1'b0, DrawX};
  assign w_y         = {1'b0, DrawY};
  assign w_y1        = w_y + 11'd1;
  assign w_y1_row    = w_y1 / L_CELL;
  assign w_y1_off    = w_y1 % L_CELL;
  assign w_y_off     = w_y % L_CELL;
  assign w_hs_rise   = hs & ~r_hs_d;
  assign w_trig_row  = (w_y1_off == 11'd0) && (w_y1_row < L_ROWS);
  assign w_trig_wrap = (w_y == L_LAST_Y);
  assign w_trigger   = w_hs_rise & (w_trig_row | w_trig_wrap);
  assign w_swap      = (DrawX == 10'd0) && (w_y_off == 11'd0);

  // Sign bit of the 12-bit difference marks pixels left of the board.
  assign w_x_diff    = {1'b0, w_x} - {1'b0, L_LEFT};
  assign w_x_rel     = w_x_diff[10:0];
  assign w_col       = CW'(w_x_rel / L_CELL);
  assign w_x_off     = w_x_rel % L_CELL;
  assign w_on_board  = ~w_x_diff[11] && (w_x < L_RIGHT) && (w_y < L_BOARD_H);
  assign w_border    = (w_x_off == 11'd0) || (w_x_off == L_CELL_M1) ||
                       (w_y_off == 11'd0) || (w_y_off == L_CELL_M1);

  assign w_y13       = {3'b000, DrawY};
  assign w_pop_top   = {6'd0, r_pop_row} * P_CELL;
  assign w_pop_bot   = w_pop_top + P_CELL;
  assign w_on_pop    = r_pop_active && (r_pop_row < L_ROWS7) &&
                       (w_x >= L_RIGHT) && (w_x < L_POP_END) &&
                       (w_y13 >= w_pop_top) && (w_y13 < w_pop_bot);

  // Row fetch FSM and the two row buffers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hs_d      <= 1'b0;
      r_row_req   <= 1'b0;
      r_row_num   <= 8'd0;
      r_fetch_err <= 1'b0;
      r_disp_sel  <= 1'b0;
      // NOTE: the row buffers are small register arrays, not RAM, so they can
      // take the asynchronous clear like any other flop.
      for (int c = 0; c < COLS; c++) begin
        r_buf0[c] <= 12'd0;
        r_buf1[c] <= 12'd0;
      end
    end else begin
      // NOTE: non-blocking everywhere here; every branch reads pre-edge state.
      r_hs_d <= hs;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state   <= S_REQ;
            r_row_req <= 1'b1;
            r_row_num <= w_trig_wrap ? 8'd0 : 8'(w_y1_row);
          end
        end
        S_REQ: begin
          if (w_swap) r_fetch_err <= 1'b1;
          if (row_ack) begin
            for (int c = 0; c < COLS; c++) begin
              if (r_disp_sel) r_buf0[c] <= row_data[12*c +: 12];
              else            r_buf1[c] <= row_data[12*c +: 12];
            end
            r_state   <= S_READY;
            r_row_req <= 1'b0;
          end
        end
        S_READY: begin
          if (w_swap) begin
            r_disp_sel <= ~r_disp_sel;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Popup lifetime: a trigger always restarts the count, even over a frame tick.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_pop_active <= 1'b0;
      r_pop_cnt    <= 6'd0;
      r_pop_row    <= 7'd0;
    end else if (pop_trigger) begin
      r_pop_active <= 1'b1;
      r_pop_cnt    <= 6'd0;
      r_pop_row    <= pop_row;
    end else if (frame_tick && r_pop_active) begin
      r_pop_cnt <= r_pop_cnt + 6'd1;
      if (r_pop_cnt + 6'd1 == L_POP_LAST) r_pop_active <= 1'b0;
    end
  end

  logic [11:0] w_cell;
  logic [8:0]  w_grey_sub;
  logic [7:0]  w_grey;

  assign w_cell     = r_disp_sel ? r_buf1[r_s1_col] : r_buf0[r_s1_col];
  assign w_grey_sub = 9'd255 - {1'b0, r_pop_cnt, 2'b00};
  assign w_grey     = w_grey_sub[8] ? 8'd0 : w_grey_sub[7:0];

  // Pixel pipeline: stage 1 classifies the pixel, stage 2 picks the colour.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_s1_region <= RG_BG;
      r_s1_col    <= '0;
      r_s1_border <= 1'b0;
      r_red       <= 8'd0;
      r_green     <= 8'd0;
      r_blue      <= 8'd0;
    end else begin
      r_s1_region <= w_on_board ? RG_BOARD : (w_on_pop ? RG_POP : RG_BG);
      r_s1_col    <= w_col;
      r_s1_border <= w_border;
      case (r_s1_region)
        RG_BOARD: begin
          if (w_cell != 12'd0 && r_s1_border) begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
          end else begin
            r_red   <= {w_cell[11:8], w_cell[11:8]};
            r_green <= {w_cell[7:4],  w_cell[7:4]};
            r_blue  <= {w_cell[3:0],  w_cell[3:0]};
          end
        end
        RG_POP: begin
          r_red   <= w_grey;
          r_green <= w_grey;
          r_blue  <= w_grey;
        end
        default: begin
          r_red   <= BG[23:16];
          r_green <= BG[15:8];
          r_blue  <= BG[7:0];
        end
      endcase
    end
  end

  assign row_req   = r_row_req;
  assign row_num   = r_row_num;
  assign fetch_err = r_fetch_err;
  assign Red       = r_red;
  assign Green     = r_green;
  assign Blue      = r_blue;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: pixel vectors go through a scoreboard
// that expects each colour exactly two clocks after the coordinates are driven.
module tb_board_renderer;

  localparam logic [23:0] BG = 24'h00FC39;

  logic         Clk = 1'b0;
  logic         reset = 1'b0;
  logic [9:0]   DrawX = 10'd650, DrawY = 10'd0;
  logic         hs = 1'b0, frame_tick = 1'b0;
  logic         row_ack = 1'b0;
  logic [119:0] row_data = '0;
  logic         pop_trigger = 1'b0;
  logic [6:0]   pop_row = 7'd0;
  logic         row_req, fetch_err;
  logic [7:0]   row_num, Red, Green, Blue;

  logic [47:0]  row_data2 = '0;
  logic         row_req2, fetch_err2;
  logic [7:0]   row_num2, Red2, Green2, Blue2;

  board_renderer dut (
    .Clk(Clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .hs(hs),
    .frame_tick(frame_tick), .row_req(row_req), .row_num(row_num),
    .row_ack(row_ack), .row_data(row_data), .pop_trigger(pop_trigger),
    .pop_row(pop_row), .Red(Red), .Green(Green), .Blue(Blue),
    .fetch_err(fetch_err)
  );

  board_renderer #(.COLS(4), .CELL_PX(8), .LEFT_X(0)) dut2 (
    .Clk(Clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .hs(hs),
    .frame_tick(frame_tick), .row_req(row_req2), .row_num(row_num2),
    .row_ack(row_ack), .row_data(row_data2), .pop_trigger(pop_trigger),
    .pop_row(pop_row), .Red(Red2), .Green(Green2), .Blue(Blue2),
    .fetch_err(fetch_err2)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    bit          d2;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    bit          d2;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compares at the negedge of the due cycle.
  always @(negedge Clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: no output sampled at cycle %0d", e.name, e.due);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check(e.name, e.d2 ? {8'd0, Red2, Green2, Blue2} : {8'd0, Red, Green, Blue}, {8'd0, e.rgb});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb,
                     input bit d2, input string name);
    vec_t v;
    v.x = x; v.y = y; v.rgb = rgb; v.d2 = d2; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      DrawX = tbl[i].x;
      DrawY = tbl[i].y;
      e.due = cyc + 2; e.rgb = tbl[i].rgb; e.d2 = tbl[i].d2; e.name = tbl[i].name;
      sb.push_back(e);
      tick();
    end
    tbl.delete();
    DrawX = 10'd650;
    repeat (3) tick();
  endtask

  task automatic hs_pulse(input logic [9:0] y);
    DrawX = 10'd650; DrawY = y; hs = 1'b1;
    tick();
    hs = 1'b0;
    tick();
  endtask

  task automatic swap_point(input logic [9:0] y);
    DrawX = 10'd0; DrawY = y;
    tick();
    DrawX = 10'd650;
    tick();
  endtask

  task automatic ack(input logic [119:0] d);
    row_data = d; row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
    tick();
  endtask

  task automatic ftick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic trigger(input logic [6:0] r);
    pop_row = r; pop_trigger = 1'b1;
    tick();
    pop_trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] d;

    // Reset state
    tick(); tick();
    check("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    check("rst_row_req", {31'd0, row_req}, 32'd0);
    check("rst_row_num", {24'd0, row_num}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Empty board, no popup, plus the narrow-board instance
    add(10'd100, 10'd100, BG,    0, "bg_left");
    add(10'd212, 10'd5,   BG,    0, "bg_edge_l");
    add(10'd213, 10'd0,   24'h0, 0, "brd_corner");
    add(10'd300, 10'd200, 24'h0, 0, "brd_empty");
    add(10'd422, 10'd5,   24'h0, 0, "brd_edge_r");
    add(10'd423, 10'd70,  BG,    0, "pop_inactive");
    add(10'd300, 10'd420, BG,    0, "below_board");
    add(10'd639, 10'd479, BG,    0, "bg_far");
    add(10'd31,  10'd0,   24'h0, 1, "d2_brd_last");
    add(10'd32,  10'd0,   BG,    1, "d2_pop_col");
    add(10'd639, 10'd479, BG,    1, "d2_far");
    run_table();

    // Trigger qualification
    hs_pulse(10'd22);
    check("no_trig_22", {31'd0, row_req}, 32'd0);
    hs_pulse(10'd419);
    check("no_trig_419", {31'd0, row_req}, 32'd0);
    hs_pulse(10'd398);
    check("trig_398_req", {31'd0, row_req}, 32'd1);
    check("trig_398_num", {24'd0, row_num}, 32'd19);
    ack('0);
    check("ack_398_req", {31'd0, row_req}, 32'd0);
    swap_point(10'd399);

    // Row 1 fetch, load and swap
    hs_pulse(10'd20);
    check("fetch1_req", {31'd0, row_req}, 32'd1);
    check("fetch1_num", {24'd0, row_num}, 32'd1);
    hs_pulse(10'd41);
    check("ignore_in_req", {24'd0, row_num}, 32'd1);
    d = '0;
    d[11:0] = 12'hF00; d[23:12] = 12'h0A5; d[119:108] = 12'h123;
    ack(d);
    check("fetch1_done", {31'd0, row_req}, 32'd0);
    hs_pulse(10'd62);
    check("ignore_in_ready", {31'd0, row_req}, 32'd0);
    swap_point(10'd21);
    add(10'd224, 10'd25, 24'hFF0000, 0, "cell0_red");
    add(10'd213, 10'd25, 24'h000000, 0, "cell0_border_l");
    add(10'd233, 10'd25, 24'h000000, 0, "cell0_border_r");
    add(10'd224, 10'd21, 24'h000000, 0, "cell0_border_t");
    add(10'd224, 10'd41, 24'h000000, 0, "cell0_border_b");
    add(10'd234, 10'd25, 24'h000000, 0, "cell1_border_l");
    add(10'd240, 10'd25, 24'h00AA55, 0, "cell1_inner");
    add(10'd250, 10'd30, 24'h00AA55, 0, "cell1_inner2");
    add(10'd300, 10'd30, 24'h000000, 0, "cell4_empty");
    add(10'd414, 10'd30, 24'h112233, 0, "cell9_inner");
    run_table();
    check("no_err_yet", {31'd0, fetch_err}, 32'd0);

    // Wrap fetch that misses its swap point
    hs_pulse(10'd479);
    check("wrap_req", {31'd0, row_req}, 32'd1);
    check("wrap_num", {24'd0, row_num}, 32'd0);
    swap_point(10'd0);
    check("miss_err", {31'd0, fetch_err}, 32'd1);
    check("miss_req_held", {31'd0, row_req}, 32'd1);
    add(10'd224, 10'd25, 24'hFF0000, 0, "old_buf_kept");
    add(10'd240, 10'd25, 24'h00AA55, 0, "old_buf_kept1");
    run_table();
    d = '0;
    d[11:0] = 12'h0F0; d[119:108] = 12'h123;
    ack(d);
    check("late_ack_req", {31'd0, row_req}, 32'd0);
    swap_point(10'd21);
    add(10'd224, 10'd25, 24'h00FF00, 0, "new_buf_cell0");
    add(10'd240, 10'd25, 24'h000000, 0, "new_buf_cell1");
    run_table();
    check("err_sticky", {31'd0, fetch_err}, 32'd1);

    // Popup fade
    trigger(7'd3);
    add(10'd433, 10'd70, 24'hFFFFFF, 0, "pop_cnt0");
    add(10'd423, 10'd63, 24'hFFFFFF, 0, "pop_corner_tl");
    add(10'd443, 10'd83, 24'hFFFFFF, 0, "pop_corner_br");
    add(10'd444, 10'd70, BG,         0, "pop_right_out");
    add(10'd433, 10'd62, BG,         0, "pop_above");
    add(10'd433, 10'd84, BG,         0, "pop_below");
    add(10'd422, 10'd70, 24'h000000, 0, "board_beside_pop");
    run_table();
    ftick(10);
    add(10'd433, 10'd70, 24'hD7D7D7, 0, "pop_cnt10");
    run_table();
    ftick(49);
    add(10'd433, 10'd70, 24'h131313, 0, "pop_cnt59");
    run_table();
    ftick(1);
    add(10'd433, 10'd70, BG, 0, "pop_expired");
    run_table();

    trigger(7'd3);
    ftick(29);
    add(10'd433, 10'd70, 24'h8B8B8B, 0, "pop_cnt29");
    run_table();
    frame_tick = 1'b1; pop_trigger = 1'b1;
    tick();
    frame_tick = 1'b0; pop_trigger = 1'b0;
    add(10'd433, 10'd70, 24'hFFFFFF, 0, "trig_beats_tick");
    run_table();
    ftick(1);
    add(10'd433, 10'd70, 24'hFBFBFB, 0, "pop_cnt1");
    run_table();

    trigger(7'd19);
    add(10'd433, 10'd410, 24'hFFFFFF, 0, "pop_last_row");
    run_table();
    trigger(7'd20);
    add(10'd433, 10'd430, BG, 0, "pop_row_oob");
    add(10'd433, 10'd410, BG, 0, "pop_row_oob_prev");
    run_table();

    // Asynchronous reset in the middle of a fetch
    hs_pulse(10'd20);
    check("pre_reset_req", {31'd0, row_req}, 32'd1);
    DrawX = 10'd224; DrawY = 10'd25;
    repeat (3) tick();
    check("pre_reset_pix", {8'd0, Red, Green, Blue}, 32'h0000FF00);
    reset = 1'b0;
    #1;
    check("async_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    check("async_req", {31'd0, row_req}, 32'd0);
    check("async_err", {31'd0, fetch_err}, 32'd0);
    tick();
    reset = 1'b1;
    row_data = '1; row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
    check("ack_after_reset", {31'd0, row_req}, 32'd0);
    swap_point(10'd21);
    add(10'd224, 10'd25, 24'h000000, 0, "no_load_after_reset");
    run_table();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: output never compared", e.name);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
